// File: rtl/abc_fetch_if.sv
// Instruction-store and decoder handshake bundle for the fetch unit.
// The master side is the fetch unit; the slave side is the store/decoder environment.
interface abc_fetch_if #(
    parameter int ICWIDTH = 8,
    parameter int IWWIDTH = 58
);
    logic               NVM_START;
    logic [ICWIDTH-1:0] NVM_ADDRESS;
    logic               NVM_STALL;
    logic [IWWIDTH-1:0] NVM_INSTRUCTION;
    logic               INSTR_VALID;
    logic               INSTR_READY;
    logic [IWWIDTH-1:0] INSTR_OUT;
    logic [ICWIDTH-1:0] INSTR_PC;
    logic               JUMP;
    logic [ICWIDTH-1:0] JUMP_ADDR;

    modport master (
        output NVM_START, NVM_ADDRESS, INSTR_VALID, INSTR_OUT, INSTR_PC,
        input  NVM_STALL, NVM_INSTRUCTION, INSTR_READY, JUMP, JUMP_ADDR
    );

    modport slave (
        input  NVM_START, NVM_ADDRESS, INSTR_VALID, INSTR_OUT, INSTR_PC,
        output NVM_STALL, NVM_INSTRUCTION, INSTR_READY, JUMP, JUMP_ADDR
    );
endinterface

// File: rtl/abc_fetch_unit.sv
// Single-outstanding instruction fetch unit: issues one store request, waits out stalls,
// holds the word for the decoder and advances or redirects the PC on accept.
module abc_fetch_unit #(
    parameter int ICWIDTH       = 8,
    parameter int ICDEPTH       = 256,
    parameter int IWWIDTH       = 58,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    abc_fetch_if.master      bus,
    output logic             BUSY,
    output logic             FETCH_ERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [ICWIDTH-1:0] LAST_PC    = ICWIDTH'(ICDEPTH - 1);
    localparam logic [ICWIDTH:0]   DEPTH_EXT  = (ICWIDTH + 1)'(ICDEPTH);
    localparam logic [7:0]         TIMEOUT_M1 = 8'(STALL_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [ICWIDTH-1:0] r_pc;
    logic [ICWIDTH-1:0] w_pc_next;
    logic [7:0]         r_stall_cnt;
    logic [7:0]         w_stall_cnt_next;
    logic [IWWIDTH-1:0] r_instr;
    logic [ICWIDTH-1:0] r_instr_pc;
    logic               r_err;
    logic               r_rst_hold;
    logic               w_capture;
    logic               w_err_set;
    logic               w_jump_bad;

    // Out-of-range test done one bit wider so ICDEPTH == 2**ICWIDTH still works.
    assign w_jump_bad = ({1'b0, bus.JUMP_ADDR} >= DEPTH_EXT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_pc_next        = r_pc;
        w_stall_cnt_next = '0;
        w_capture        = 1'b0;
        w_err_set        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // r_rst_hold keeps the first request one extra cycle clear of reset.
                if (RUN && !r_err && !r_rst_hold) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.NVM_STALL) begin
                    if (r_stall_cnt == TIMEOUT_M1) begin
                        w_err_set = 1'b1;
                        w_next    = S_IDLE;
                    end else begin
                        w_stall_cnt_next = r_stall_cnt + 8'd1;
                    end
                end else begin
                    w_capture = 1'b1;
                    w_next    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.INSTR_READY) begin
                    w_next = RUN ? S_REQ : S_IDLE;
                    if (bus.JUMP) begin
                        if (w_jump_bad) begin
                            w_err_set = 1'b1;
                            w_pc_next = '0;
                            w_next    = S_IDLE;
                        end else begin
                            w_pc_next = bus.JUMP_ADDR;
                        end
                    end else begin
                        w_pc_next = (r_pc == LAST_PC) ? '0 : r_pc + 1'b1;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc        <= '0;
            r_stall_cnt <= '0;
            r_instr     <= '0;
            r_instr_pc  <= '0;
            r_err       <= 1'b0;
            r_rst_hold  <= 1'b1;
        end else begin
            r_pc        <= w_pc_next;
            r_stall_cnt <= w_stall_cnt_next;
            r_rst_hold  <= 1'b0;
            if (w_capture) begin
                r_instr    <= bus.NVM_INSTRUCTION;
                r_instr_pc <= r_pc;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // PC only moves on accept or error, so it stays stable from START through capture.
    assign bus.NVM_START   = (r_state == S_REQ);
    assign bus.NVM_ADDRESS = r_pc;
    assign bus.INSTR_VALID = (r_state == S_HOLD);
    assign bus.INSTR_OUT   = r_instr;
    assign bus.INSTR_PC    = r_instr_pc;
    assign BUSY            = (r_state != S_IDLE);
    assign FETCH_ERR       = r_err;

endmodule

// File: tb/tb_abc_fetch_unit.sv
// Directed bench for abc_fetch_unit (ICDEPTH=200, STALL_TIMEOUT=64).
module tb_abc_fetch_unit;

    logic clk;
    logic rst;
    logic run;
    logic busy;
    logic fetch_err;
    int   total;
    int   bad;

    abc_fetch_if #(.ICWIDTH(8), .IWWIDTH(58)) bus ();

    abc_fetch_unit #(
        .ICWIDTH(8),
        .ICDEPTH(200),
        .IWWIDTH(58),
        .STALL_TIMEOUT(64)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .RUN(run),
        .bus(bus),
        .BUSY(busy),
        .FETCH_ERR(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start"}, 64'(bus.NVM_START), 64'd0);
        chk({tag, "_addr"},  64'(bus.NVM_ADDRESS), 64'd0);
        chk({tag, "_valid"}, 64'(bus.INSTR_VALID), 64'd0);
        chk({tag, "_out"},   64'(bus.INSTR_OUT), 64'd0);
        chk({tag, "_pc"},    64'(bus.INSTR_PC), 64'd0);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_err"},   64'(fetch_err), 64'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        run = 1'b0;
        bus.NVM_STALL       = 1'b0;
        bus.NVM_INSTRUCTION = '0;
        bus.INSTR_READY     = 1'b0;
        bus.JUMP            = 1'b0;
        bus.JUMP_ADDR       = '0;
        step();
        step();
        chk_reset_vals("reset");

        // Release reset with RUN high: first START two cycles later
        rst = 1'b0;
        run = 1'b1;
        bus.INSTR_READY = 1'b1;
        step();
        chk("post_rst_no_start", 64'(bus.NVM_START), 64'd0);
        chk("post_rst_idle", 64'(busy), 64'd0);
        step();

        // Streaming fetch: addresses 0..3, one word per 3 cycles
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stream%0d_start", k), 64'(bus.NVM_START), 64'd1);
            chk($sformatf("stream%0d_addr", k), 64'(bus.NVM_ADDRESS), 64'(k));
            chk($sformatf("stream%0d_busy", k), 64'(busy), 64'd1);
            bus.NVM_INSTRUCTION = 58'h1000 + 58'(k);
            step();
            chk($sformatf("stream%0d_wait_start", k), 64'(bus.NVM_START), 64'd0);
            chk($sformatf("stream%0d_wait_valid", k), 64'(bus.INSTR_VALID), 64'd0);
            step();
            chk($sformatf("stream%0d_valid", k), 64'(bus.INSTR_VALID), 64'd1);
            chk($sformatf("stream%0d_out", k), 64'(bus.INSTR_OUT), 64'h1000 + 64'(k));
            chk($sformatf("stream%0d_ipc", k), 64'(bus.INSTR_PC), 64'(k));
            step();
        end

        // Stall of 5 WAIT cycles on address 4
        chk("stall_start", 64'(bus.NVM_START), 64'd1);
        chk("stall_addr", 64'(bus.NVM_ADDRESS), 64'd4);
        bus.NVM_STALL   = 1'b1;
        bus.INSTR_READY = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_w%0d_valid", i), 64'(bus.INSTR_VALID), 64'd0);
            chk($sformatf("stall_w%0d_busy", i), 64'(busy), 64'd1);
            step();
        end
        bus.NVM_STALL       = 1'b0;
        bus.NVM_INSTRUCTION = 58'h2AB_CDEF_0123;
        chk("stall_fall_valid", 64'(bus.INSTR_VALID), 64'd0);
        step();
        bus.NVM_INSTRUCTION = 58'h155_5555_5555;
        chk("stall_valid", 64'(bus.INSTR_VALID), 64'd1);
        chk("stall_out", 64'(bus.INSTR_OUT), 64'h2AB_CDEF_0123);
        chk("stall_ipc", 64'(bus.INSTR_PC), 64'd4);

        // HOLD with READY low and JUMP toggling: nothing moves
        bus.JUMP_ADDR = 8'd5;
        for (int i = 0; i < 10; i++) begin
            bus.JUMP = i[0];
            step();
            chk($sformatf("hold%0d_valid", i), 64'(bus.INSTR_VALID), 64'd1);
            chk($sformatf("hold%0d_out", i), 64'(bus.INSTR_OUT), 64'h2AB_CDEF_0123);
            chk($sformatf("hold%0d_addr", i), 64'(bus.NVM_ADDRESS), 64'd4);
            chk($sformatf("hold%0d_start", i), 64'(bus.NVM_START), 64'd0);
        end

        // Jump to 199, then wrap to 0, then jump to 0x2A
        bus.JUMP        = 1'b1;
        bus.JUMP_ADDR   = 8'd199;
        bus.INSTR_READY = 1'b1;
        step();
        bus.JUMP = 1'b0;
        chk("j199_start", 64'(bus.NVM_START), 64'd1);
        chk("j199_addr", 64'(bus.NVM_ADDRESS), 64'd199);
        bus.NVM_INSTRUCTION = 58'h0C7;
        step();
        step();
        chk("j199_ipc", 64'(bus.INSTR_PC), 64'd199);
        chk("j199_out", 64'(bus.INSTR_OUT), 64'h0C7);
        step();
        chk("wrap_start", 64'(bus.NVM_START), 64'd1);
        chk("wrap_addr", 64'(bus.NVM_ADDRESS), 64'd0);
        step();
        step();
        chk("wrap_ipc", 64'(bus.INSTR_PC), 64'd0);
        bus.JUMP      = 1'b1;
        bus.JUMP_ADDR = 8'h2A;
        step();
        bus.JUMP = 1'b0;
        chk("j2a_start", 64'(bus.NVM_START), 64'd1);
        chk("j2a_addr", 64'(bus.NVM_ADDRESS), 64'h2A);
        step();
        step();
        chk("j2a_ipc", 64'(bus.INSTR_PC), 64'h2A);

        // Illegal jump target 210
        bus.JUMP      = 1'b1;
        bus.JUMP_ADDR = 8'd210;
        step();
        bus.JUMP = 1'b0;
        chk("badj_err", 64'(fetch_err), 64'd1);
        chk("badj_busy", 64'(busy), 64'd0);
        chk("badj_valid", 64'(bus.INSTR_VALID), 64'd0);
        chk("badj_pc0", 64'(bus.NVM_ADDRESS), 64'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("badj_idle%0d_start", i), 64'(bus.NVM_START), 64'd0);
            chk($sformatf("badj_idle%0d_busy", i), 64'(busy), 64'd0);
            chk($sformatf("badj_idle%0d_err", i), 64'(fetch_err), 64'd1);
        end

        // Reset clears the error; fetch addr 0 then time out on addr 1
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("clr_err", 64'(fetch_err), 64'd0);
        step();
        step();
        chk("to_pre_start", 64'(bus.NVM_START), 64'd1);
        bus.NVM_INSTRUCTION = 58'h3FF_0000_0001;
        step();
        step();
        chk("to_pre_out", 64'(bus.INSTR_OUT), 64'h3FF_0000_0001);
        step();
        chk("to_start", 64'(bus.NVM_START), 64'd1);
        chk("to_addr", 64'(bus.NVM_ADDRESS), 64'd1);
        bus.NVM_STALL = 1'b1;
        step();
        for (int i = 1; i <= 64; i++) begin
            chk($sformatf("to_w%0d_valid", i), 64'(bus.INSTR_VALID), 64'd0);
            chk($sformatf("to_w%0d_err", i), 64'(fetch_err), 64'd0);
            chk($sformatf("to_w%0d_busy", i), 64'(busy), 64'd1);
            step();
        end
        chk("to_err", 64'(fetch_err), 64'd1);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_valid", 64'(bus.INSTR_VALID), 64'd0);
        chk("to_pc_kept", 64'(bus.NVM_ADDRESS), 64'd1);
        chk("to_out_kept", 64'(bus.INSTR_OUT), 64'h3FF_0000_0001);
        step();
        chk("to_stay_start", 64'(bus.NVM_START), 64'd0);

        // Reset pulsed mid-WAIT after a captured word
        rst = 1'b1;
        bus.NVM_STALL = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        bus.NVM_INSTRUCTION = 58'h0AB_CDEF;
        step();
        step();
        chk("mid_pre_out", 64'(bus.INSTR_OUT), 64'h0AB_CDEF);
        step();
        chk("mid_addr1", 64'(bus.NVM_ADDRESS), 64'd1);
        bus.NVM_STALL = 1'b1;
        step();
        step();
        chk("mid_wait_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        chk_reset_vals("midrst");
        rst = 1'b0;
        bus.NVM_STALL = 1'b0;
        step();
        chk("midrst_after_valid", 64'(bus.INSTR_VALID), 64'd0);
        chk("midrst_after_out", 64'(bus.INSTR_OUT), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/abc_fetch_unit.md
ABC_FETCH_UNIT -- requirements
Module: abc_fetch_unit

Interface
REQ-001 Parameter ICWIDTH, default 8, SHALL set the instruction address width.
REQ-002 Parameter ICDEPTH, default 256, SHALL set the number of valid instruction slots; legal addresses are 0..ICDEPTH-1.
REQ-003 Parameter IWWIDTH, default 58, SHALL set the instruction word width.
REQ-004 Parameter STALL_TIMEOUT, default 64, SHALL set the maximum number of consecutive stalled wait cycles; legal range 1..255.
REQ-005 Port list (name, direction, width, meaning) SHALL be exactly:
- CLK  in  1  sole clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- RUN  in  1  level enable for the fetch sequence.
- NVM_START  out  1  one-cycle fetch strobe to the instruction store.
- NVM_ADDRESS  out  ICWIDTH  fetch address, held stable from NVM_START until capture.
- NVM_STALL  in  1  instruction store busy; the word is not yet valid.
- NVM_INSTRUCTION  in  IWWIDTH  instruction word from the instruction store.
- INSTR_VALID  out  1  instruction register holds a word for the decoder.
- INSTR_READY  in  1  decoder accepts the word.
- INSTR_OUT  out  IWWIDTH  instruction register contents.
- INSTR_PC  out  ICWIDTH  address the word in INSTR_OUT was fetched from.
- JUMP  in  1  redirect request, qualified by the accept handshake.
- JUMP_ADDR  in  ICWIDTH  redirect target.
- BUSY  out  1  state is not IDLE.
- FETCH_ERR  out  1  sticky error flag.

Function
REQ-006 The FSM SHALL have exactly four states: IDLE, REQ, WAIT and HOLD.
REQ-007 IDLE SHALL go to REQ when RUN=1 and FETCH_ERR=0, and SHALL otherwise remain in IDLE.
REQ-008 REQ SHALL assert NVM_START for exactly one cycle with NVM_ADDRESS=PC, then go to WAIT.
REQ-009 WAIT SHALL remain in WAIT while NVM_STALL=1.
REQ-010 In the first WAIT cycle with NVM_STALL=0, the block SHALL capture NVM_INSTRUCTION into INSTR_OUT and PC into INSTR_PC, and go to HOLD.
REQ-011 INSTR_VALID SHALL be 1 in HOLD and 0 in every other state.
REQ-012 INSTR_OUT and INSTR_PC SHALL hold stable for the whole of HOLD.
REQ-013 Accept SHALL occur when INSTR_VALID=1 and INSTR_READY=1 in the same cycle.
REQ-014 On accept with JUMP=0, the next PC SHALL be PC+1, wrapping from ICDEPTH-1 to 0; ICDEPTH need not be a power of two.
REQ-015 On accept with JUMP=1 and JUMP_ADDR<ICDEPTH, the next PC SHALL be JUMP_ADDR.
REQ-016 JUMP SHALL be ignored in any cycle without an accept.
REQ-017 On accept with JUMP=1 and JUMP_ADDR>=ICDEPTH, the block SHALL set FETCH_ERR, set PC to 0, and go to IDLE.
REQ-018 After an accept, the next state SHALL be REQ if RUN=1, otherwise IDLE.
REQ-019 Minimum latency SHALL be: NVM_START in cycle n, INSTR_VALID=1 in cycle n+2 when NVM_STALL=0; back-to-back accepts SHALL give one instruction per 3 cycles.
REQ-020 RUN deasserted during REQ or WAIT SHALL NOT abort the fetch; it completes to HOLD.
REQ-021 A stall counter SHALL count consecutive WAIT cycles with NVM_STALL=1.
REQ-022 When the stall counter reaches STALL_TIMEOUT, the block SHALL set FETCH_ERR, capture nothing, and go to IDLE; PC SHALL be unchanged.
REQ-023 FETCH_ERR SHALL be cleared only by RST; while it is 1, IDLE SHALL not leave IDLE.
REQ-024 NVM_START SHALL never be asserted outside REQ.
REQ-025 The block SHALL never have more than one fetch outstanding.
REQ-026 BUSY SHALL be 1 in REQ, WAIT and HOLD.

Reset
REQ-027 RST=1 sampled on CLK SHALL force state IDLE, PC 0, stall counter 0, NVM_START 0, NVM_ADDRESS 0, INSTR_VALID 0, INSTR_OUT 0, INSTR_PC 0, BUSY 0 and FETCH_ERR 0.
REQ-028 RST asserted in any state, including mid-WAIT, SHALL abandon the fetch without capturing.
REQ-029 The first NVM_START after RST falls SHALL occur no earlier than 2 cycles after RST deasserts with RUN=1.

Verification
REQ-030 Scenario: RUN=1, NVM_STALL=0, INSTR_READY=1 -> NVM_ADDRESS sequence 0,1,2,3; one INSTR_VALID pulse every 3 cycles; INSTR_PC matches each address.
REQ-031 Scenario: NVM_STALL held high for 5 cycles after START -> INSTR_VALID rises exactly 1 cycle after NVM_STALL falls; INSTR_OUT equals the NVM_INSTRUCTION value in that cycle.
REQ-032 Scenario: ICDEPTH=200, PC=199, accept with JUMP=0 -> next NVM_ADDRESS=0; then accept with JUMP=1, JUMP_ADDR=0x2A -> next NVM_ADDRESS=0x2A.
REQ-033 Scenario: accept with JUMP=1, JUMP_ADDR=210 (ICDEPTH=200) -> FETCH_ERR=1, BUSY=0, no further NVM_START until RST.
REQ-034 Scenario: NVM_STALL stuck at 1 with STALL_TIMEOUT=64 -> FETCH_ERR=1 after 64 WAIT cycles, INSTR_VALID never asserted.
REQ-035 Scenario: INSTR_READY=0 for 10 cycles in HOLD with JUMP toggling -> INSTR_OUT stable, PC unchanged; RST pulsed mid-WAIT -> all outputs return to reset values the next cycle.
